ber_aligner: RTL

Receive-side PRBS checker, the counterpart of the per-branch PRBS generator. It compares the sliced receiver output (dx) with the locally generated reference (sx) and finds the unknown pipeline latency between them by sweeping candidate delays. After lock it counts compared bits and bit errors for I or R branch BER measurement. One instance sits per branch, clocked by the symbol-rate enable strobe.

---
 rtl/ber_aligner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ber_aligner.sv
// Receive-side PRBS checker: sweeps candidate latencies between the local reference (sx)
// and the sliced data (dx), locks on the first error-free or least-error delay, then counts bits/errors.
module ber_aligner #(
  parameter int MAX_DELAY  = 511,
  parameter int SEARCH_LEN = 511,
  parameter int CNT_W      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           sx,
  input  logic                           dx,
  output logic                           o_locked,
  output logic [$clog2(MAX_DELAY+1)-1:0] o_delay,
  output logic [CNT_W-1:0]               o_bit_count,
  output logic [CNT_W-1:0]               o_err_count,
  output logic                           error_flag
);
  localparam int DLY_W = $clog2(MAX_DELAY+1);
  localparam int WIN_W = $clog2(SEARCH_LEN+1);

  typedef enum logic {SEARCH, MEASURE} state_t;

  state_t               state_q, state_d;
  logic [MAX_DELAY-1:0] sr_q, sr_d;
  logic [DLY_W-1:0]     delay_q, delay_d, best_q, best_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d, win_err_q, win_err_d, min_err_q, min_err_d;
  logic [WIN_W-1:0]     total;
  logic                 locked_q, locked_d, flag_q, flag_d;
  logic [CNT_W-1:0]     bit_q, bit_d, err_q, err_d;
  logic [MAX_DELAY:0]   taps;
  logic                 e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Tap 0 is the live reference bit; tap d is sx from d enables ago.
  assign taps = {sr_q, sx};
  assign e    = dx ^ taps[delay_q];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    delay_d   = delay_q;
    best_d    = best_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    min_err_d = min_err_q;
    locked_d  = locked_q;
    bit_d     = bit_q;
    err_d     = err_q;
    flag_d    = flag_q;
    total     = '0;
    if (enable) begin
      sr_d = {sr_q[MAX_DELAY-2:0], sx};
      case (state_q)
        SEARCH: begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          win_err_d = win_err_q + WIN_W'(e);
          if (win_cnt_q == WIN_W'(SEARCH_LEN-1)) begin
            total = win_err_q + WIN_W'(e);
            if (total == '0) begin
              state_d  = MEASURE;
              locked_d = 1'b1;
            end else begin
              if (total < min_err_q) begin
                min_err_d = total;
                best_d    = delay_q;
              end
              if (delay_q == DLY_W'(MAX_DELAY)) begin
                // best_d already folds in this final window's result
                state_d  = MEASURE;
                locked_d = 1'b1;
                delay_d  = best_d;
              end else begin
                delay_d   = delay_q + DLY_W'(1);
                win_cnt_d = '0;
                win_err_d = '0;
              end
            end
          end
        end
        MEASURE: begin
          bit_d = sat_inc(bit_q, 1'b1);
          err_d = sat_inc(err_q, e);
        end
        default: state_d = SEARCH;
      endcase
      flag_d = !locked_d || (err_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      delay_q   <= '0;
      best_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      min_err_q <= '1;
      locked_q  <= 1'b0;
      bit_q     <= '0;
      err_q     <= '0;
      flag_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      delay_q   <= delay_d;
      best_q    <= best_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      min_err_q <= min_err_d;
      locked_q  <= locked_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      flag_q    <= flag_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_delay     = delay_q;
  assign o_bit_count = bit_q;
  assign o_err_count = err_q;
  assign error_flag  = flag_q;
endmodule
